mc_control_ws: RTL and testbench

MC_CONTROL_WS -- requirements
Module: mc_control_ws

---
 rtl/mc_ctrl_pkg.sv | 45 ++++
 rtl/mc_control_ws_if.sv | 47 ++++
 rtl/mc_wait_timer.sv | 25 ++
 rtl/mc_control_ws.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_control_ws.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// opcode and funct constants, trap cause codes and fixed ALU opcodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_RTYPE     = 4'd2,
    S_RITYPE    = 4'd3,
    S_RTYPE_END = 4'd4,
    S_LW1       = 4'd5,
    S_LW2       = 4'd6,
    S_SW        = 4'd7,
    S_JALR      = 4'd8,
    S_BRANCH    = 4'd9,
    S_BRANCH2   = 4'd10,
    S_JAL       = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    TC_NONE      = 2'd0,
    TC_ILLEGAL   = 2'd1,
    TC_TIMEOUT   = 2'd2,
    TC_BAD_STATE = 2'd3
  } trap_cause_t;

  localparam logic [2:0] OP_RTYPE  = 3'b000;
  localparam logic [2:0] OP_IMM    = 3'b001;
  localparam logic [2:0] OP_RITYPE = 3'b010;
  localparam logic [2:0] OP_NOP    = 3'b011;
  localparam logic [2:0] OP_JAL    = 3'b100;

  localparam logic [3:0] FN_LW   = 4'b1001;
  localparam logic [3:0] FN_SW   = 4'b1010;
  localparam logic [3:0] FN_JALR = 4'b1011;

  // Largest funct value passed straight through as an ALU opcode.
  localparam logic [3:0] FN_ALU_MAX = 4'd8;

  localparam logic [3:0] ALU_LINK   = 4'b0111;
  localparam logic [3:0] ALU_BRCMP  = 4'b1001;
  localparam logic [3:0] ALU_BRTGT  = 4'b0001;

endpackage

// File: rtl/mc_control_ws_if.sv
// Controller bus: instruction fields and memory/trap handshakes in, datapath
// control strobes and status out.
//   master : the controller (drives control outputs)
//   slave  : the datapath/bench side (drives opcode, funct, handshakes)
interface mc_control_ws_if #(
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);
  logic [2:0]         opcode;
  logic [FUNCT_W-1:0] funct;
  logic               mem_ready;
  logic               trap_ack;

  logic               branch;
  logic               IoD;
  logic               IRWrite;
  logic               Mem2Reg;
  logic               MemR;
  logic               MemW;
  logic               PCSrc;
  logic               PCWrite;
  logic               RegWrite;
  logic               retire;
  logic               trap;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         branchType;
  logic [ALUOP_W-1:0] ALUOp;
  logic [3:0]         state;
  logic [1:0]         trap_cause;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    input  opcode, funct, mem_ready, trap_ack,
    output branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc, PCWrite,
           RegWrite, retire, trap, ALUSrcA, ALUSrcB, branchType, ALUOp,
           state, trap_cause, instr_count
  );

  modport slave (
    output opcode, funct, mem_ready, trap_ack,
    input  branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc, PCWrite,
           RegWrite, retire, trap, ALUSrcA, ALUSrcB, branchType, ALUOp,
           state, trap_cause, instr_count
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait timer. Counts cycles spent waiting on mem_ready and flags when
// the count has reached TIMEOUT.
//   CLK, Reset : clock, asynchronous active-high reset
//   count_en   : controller is in a memory-wait state with mem_ready low
//   clear      : controller is changing state this cycle (has priority)
//   timeout    : count equals TIMEOUT
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);
  logic [3:0] cnt_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)         cnt_q <= '0;
    else if (clear)    cnt_q <= '0;
    else if (count_en) cnt_q <= cnt_q + 4'd1;
  end

  assign timeout = (cnt_q == 4'(TIMEOUT));
endmodule

// File: rtl/mc_control_ws.sv
// Multi-cycle processor controller with memory wait-state timeout and traps.
//   CLK, Reset : clock, asynchronous active-high reset
//   bus        : master side of mc_control_ws_if (instruction fields,
//                mem_ready/trap_ack in; control strobes, state, trap_cause,
//                instr_count out)
// Control outputs are decoded from the state register; IRWrite/PCWrite in
// FETCH and retire in SW/DECODE also depend on the current inputs.
module mc_control_ws
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  mc_control_ws_if.master   bus
);

  function automatic logic [ALUOP_W-1:0] alu_from_funct(input logic [FUNCT_W-1:0] f);
    if (f <= FUNCT_W'(FN_ALU_MAX)) return ALUOP_W'(f);
    return '1;
  endfunction

  state_t           state_q, state_d;
  trap_cause_t      cause_q, cause_d;
  logic [CNT_W-1:0] count_q;
  logic             timeout, wait_en, state_chg;

  logic br, iod, ir_wr, mem2reg, mem_rd, mem_wr, pc_src, pc_wr, reg_wr, retire, trap;
  logic [1:0]         src_a, src_b, br_type;
  logic [ALUOP_W-1:0] alu_op;

  assign wait_en   = (state_q inside {S_FETCH, S_LW1, S_SW}) && !bus.mem_ready;
  assign state_chg = (state_d != state_q);

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK      (CLK),
    .Reset    (Reset),
    .count_en (wait_en),
    .clear    (state_chg),
    .timeout  (timeout)
  );

  always_comb begin
    state_d = state_q;
    cause_d = TC_NONE;
    br = 1'b0; iod = 1'b0; ir_wr = 1'b0; mem2reg = 1'b0; mem_rd = 1'b0;
    mem_wr = 1'b0; pc_src = 1'b0; pc_wr = 1'b0; reg_wr = 1'b0;
    retire = 1'b0; trap = 1'b0;
    src_a = 2'd0; src_b = 2'd0; br_type = 2'd0;
    alu_op = '1;

    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        alu_op = '0;
        src_b  = 2'd1;
        // Completion beats timeout when both happen in the same cycle.
        if (bus.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE: state_d = S_RTYPE;
          OP_IMM: begin
            if (bus.funct == FUNCT_W'(FN_JALR)) state_d = S_JALR;
            else if (bus.funct[3:2] == 2'b11)   state_d = S_BRANCH;
            else                                state_d = S_RITYPE;
          end
          OP_RITYPE: state_d = S_RITYPE;
          OP_NOP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_JAL: state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end
      S_RTYPE: begin
        alu_op  = alu_from_funct(bus.funct);
        src_a   = 2'd2;
        src_b   = 2'd0;
        state_d = S_RTYPE_END;
      end
      S_RITYPE: begin
        alu_op = alu_from_funct(bus.funct);
        src_a  = 2'd2;
        src_b  = 2'd2;
        if (bus.funct == FUNCT_W'(FN_LW))      state_d = S_LW1;
        else if (bus.funct == FUNCT_W'(FN_SW)) state_d = S_SW;
        else                                   state_d = S_RTYPE_END;
      end
      S_RTYPE_END: begin
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_LW1: begin
        iod    = 1'b1;
        mem_rd = 1'b1;
        if (bus.mem_ready) state_d = S_LW2;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_LW2: begin
        mem2reg = 1'b1;
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_SW: begin
        iod    = 1'b1;
        mem_wr = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_JALR: begin
        alu_op  = ALUOP_W'(ALU_LINK);
        src_a   = 2'd3;
        src_b   = 2'd1;
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        alu_op  = ALUOP_W'(ALU_LINK);
        src_a   = 2'd3;
        src_b   = 2'd1;
        pc_wr   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_op  = ALUOP_W'(ALU_BRCMP);
        src_b   = 2'd2;
        br      = 1'b1;
        br_type = bus.funct[1:0];
        state_d = S_BRANCH2;
      end
      S_BRANCH2: begin
        alu_op  = ALUOP_W'(ALU_BRTGT);
        src_a   = 2'd2;
        br      = 1'b1;
        br_type = bus.funct[1:0];
        pc_src  = 1'b1;
        pc_wr   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (bus.trap_ack) state_d = S_FETCH;
      end
      default: begin
        // Corrupted state register: park in TRAP.
        state_d = S_TRAP;
        cause_d = TC_BAD_STATE;
      end
    endcase

    // Reset masks the FETCH decode so the datapath sees an idle controller.
    if (Reset) begin
      br = 1'b0; iod = 1'b0; ir_wr = 1'b0; mem2reg = 1'b0; mem_rd = 1'b0;
      mem_wr = 1'b0; pc_src = 1'b0; pc_wr = 1'b0; reg_wr = 1'b0;
      retire = 1'b0; trap = 1'b0;
      src_a = 2'd0; src_b = 2'd0; br_type = 2'd0;
      alu_op = '1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cause_q <= TC_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // Cause is captured on trap entry and held afterwards.
      if (state_d == S_TRAP && state_q != S_TRAP) cause_q <= cause_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.branch      = br;
  assign bus.IoD         = iod;
  assign bus.IRWrite     = ir_wr;
  assign bus.Mem2Reg     = mem2reg;
  assign bus.MemR        = mem_rd;
  assign bus.MemW        = mem_wr;
  assign bus.PCSrc       = pc_src;
  assign bus.PCWrite     = pc_wr;
  assign bus.RegWrite    = reg_wr;
  assign bus.retire      = retire;
  assign bus.trap        = trap;
  assign bus.ALUSrcA     = src_a;
  assign bus.ALUSrcB     = src_b;
  assign bus.branchType  = br_type;
  assign bus.ALUOp       = alu_op;
  assign bus.state       = state_q;
  assign bus.trap_cause  = cause_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mc_control_ws.sv
// Bench for mc_control_ws: directed instruction sequences, a cycle model
// compared on every falling edge, and literal spot checks.
module tb_mc_control_ws;
  localparam int FUNCT_W = 4;
  localparam int ALUOP_W = 4;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;   // small so the counter wrap is reachable

  // state encodings
  localparam int FETCH = 0, DECODE = 1, RTYPE = 2, RITYPE = 3, RTYPE_END = 4,
                 LW1 = 5, LW2 = 6, SW = 7, JALR = 8, BRANCH = 9, BRANCH2 = 10,
                 JAL = 11, TRAP = 12;
  // bit positions in the packed flag word
  localparam int F_BR = 10, F_IOD = 9, F_IRW = 8, F_M2R = 7, F_MEMR = 6,
                 F_MEMW = 5, F_PCSRC = 4, F_PCW = 3, F_REGW = 2, F_RET = 1,
                 F_TRAP = 0;

  typedef struct {
    int flags;
    int srca;
    int srcb;
    int btype;
    int aluop;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_state, m_wait, m_cause, m_count;

  mc_control_ws_if #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  mc_control_ws #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int fb(input int b);
    return 1 << b;
  endfunction

  function automatic int dut_flags();
    int r;
    r = 0;
    if (bus.branch)   r |= fb(F_BR);
    if (bus.IoD)      r |= fb(F_IOD);
    if (bus.IRWrite)  r |= fb(F_IRW);
    if (bus.Mem2Reg)  r |= fb(F_M2R);
    if (bus.MemR)     r |= fb(F_MEMR);
    if (bus.MemW)     r |= fb(F_MEMW);
    if (bus.PCSrc)    r |= fb(F_PCSRC);
    if (bus.PCWrite)  r |= fb(F_PCW);
    if (bus.RegWrite) r |= fb(F_REGW);
    if (bus.retire)   r |= fb(F_RET);
    if (bus.trap)     r |= fb(F_TRAP);
    return r;
  endfunction

  // Expected outputs and successor for one cycle, from the instruction rules.
  function automatic void model(input int st, input int wt, input int op, input int fn,
                                input bit mr, input bit ack, output exp_t e,
                                output int nst, output int nwt, output int nc);
    int alu_fn;
    bit waiting;
    e = '{flags: 0, srca: 0, srcb: 0, btype: 0, aluop: 15};
    nst = st;
    nc = -1;
    alu_fn = (fn <= 8) ? fn : 15;
    waiting = (st == FETCH || st == LW1 || st == SW) && !mr;
    if (waiting && wt == TIMEOUT) begin
      nst = TRAP;
      nc = 2;
    end
    case (st)
      FETCH: begin
        e.flags = fb(F_MEMR); e.aluop = 0; e.srcb = 1;
        if (mr) begin e.flags |= fb(F_IRW) | fb(F_PCW); nst = DECODE; end
      end
      DECODE: begin
        if (op == 0) nst = RTYPE;
        else if (op == 1) nst = (fn == 11) ? JALR : ((fn >> 2) == 3) ? BRANCH : RITYPE;
        else if (op == 2) nst = RITYPE;
        else if (op == 3) begin e.flags = fb(F_RET); nst = FETCH; end
        else if (op == 4) nst = JAL;
        else begin nst = TRAP; nc = 1; end
      end
      RTYPE: begin e.aluop = alu_fn; e.srca = 2; e.srcb = 0; nst = RTYPE_END; end
      RITYPE: begin
        e.aluop = alu_fn; e.srca = 2; e.srcb = 2;
        nst = (fn == 9) ? LW1 : (fn == 10) ? SW : RTYPE_END;
      end
      RTYPE_END: begin e.flags = fb(F_REGW) | fb(F_RET); nst = FETCH; end
      LW1: begin e.flags = fb(F_IOD) | fb(F_MEMR); if (mr) nst = LW2; end
      LW2: begin e.flags = fb(F_M2R) | fb(F_REGW) | fb(F_RET); nst = FETCH; end
      SW: begin
        e.flags = fb(F_IOD) | fb(F_MEMW);
        if (mr) begin e.flags |= fb(F_RET); nst = FETCH; end
      end
      JALR: begin e.aluop = 7; e.srca = 3; e.srcb = 1; e.flags = fb(F_REGW) | fb(F_RET); nst = FETCH; end
      JAL:  begin e.aluop = 7; e.srca = 3; e.srcb = 1; e.flags = fb(F_PCW) | fb(F_RET); nst = FETCH; end
      BRANCH: begin e.aluop = 9; e.srcb = 2; e.flags = fb(F_BR); e.btype = fn & 3; nst = BRANCH2; end
      BRANCH2: begin
        e.aluop = 1; e.srca = 2; e.btype = fn & 3;
        e.flags = fb(F_BR) | fb(F_PCSRC) | fb(F_PCW) | fb(F_RET);
        nst = FETCH;
      end
      TRAP: begin e.flags = fb(F_TRAP); if (ack) nst = FETCH; end
      default: begin nst = TRAP; nc = 3; end
    endcase
    nwt = (nst != st) ? 0 : (waiting ? wt + 1 : wt);
  endfunction

  // Per-cycle comparison against the model.
  initial begin
    exp_t e;
    int nst, nwt, nc;
    bit in_rst;
    m_state = 0; m_wait = 0; m_cause = 0; m_count = 0;
    forever begin
      @(negedge CLK);
      in_rst = Reset;
      if (in_rst) begin
        m_state = 0; m_wait = 0; m_cause = 0; m_count = 0;
        check("rst_flags", dut_flags(), 0);
        check("rst_aluop", bus.ALUOp, 15);
        check("rst_srcs", {bus.ALUSrcA, bus.ALUSrcB, bus.branchType}, 0);
        check("rst_state", bus.state, 0);
        check("rst_count", bus.instr_count, 0);
        check("rst_cause", bus.trap_cause, 0);
      end else begin
        model(m_state, m_wait, int'(bus.opcode), int'(bus.funct), bus.mem_ready,
              bus.trap_ack, e, nst, nwt, nc);
        check("m_flags", dut_flags(), e.flags);
        check("m_srca", bus.ALUSrcA, e.srca);
        check("m_srcb", bus.ALUSrcB, e.srcb);
        check("m_btype", bus.branchType, e.btype);
        check("m_aluop", bus.ALUOp, e.aluop);
        check("m_state", bus.state, m_state);
        check("m_cause", bus.trap_cause, m_cause);
        check("m_count", bus.instr_count, m_count);
      end
      @(posedge CLK);
      if (!in_rst && !Reset) begin
        m_state = nst;
        m_wait = nwt;
        if (nc >= 0) m_cause = nc;
        if ((e.flags & fb(F_RET)) != 0) m_count = (m_count + 1) % (1 << CNT_W);
      end
    end
  end

  task automatic drive(input int op, input int fn, input bit mr, input bit ack);
    bus.opcode    = 3'(op);
    bus.funct     = FUNCT_W'(fn);
    bus.mem_ready = mr;
    bus.trap_ack  = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int op, input int fn, input bit mr, input int n);
    repeat (n) begin
      drive(op, fn, mr, 1'b0);
      tick();
    end
  endtask

  initial begin
    bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0; bus.trap_ack = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("lit_reset_state", bus.state, 0);
    check("lit_reset_aluop", bus.ALUOp, 15);
    check("lit_reset_memr", bus.MemR, 0);
    Reset = 1'b0;

    // R-type: FETCH, DECODE, RTYPE, RTYPE_END
    drive(0, 1, 1, 0); check("lit_rt_irwrite", bus.IRWrite, 1); tick();
    drive(0, 1, 1, 0); check("lit_rt_decode", bus.state, DECODE); tick();
    drive(0, 1, 1, 0); check("lit_rt_aluop", bus.ALUOp, 1); tick();
    drive(0, 1, 1, 0); check("lit_rt_regwrite", bus.RegWrite, 1); tick();
    check("lit_rt_count", bus.instr_count, 1);

    // Load with three wait cycles in LW1
    run(2, 9, 1, 2);
    drive(2, 9, 0, 0); check("lit_ld_ritype_aluop", bus.ALUOp, 15); tick();
    for (int i = 0; i < 4; i++) begin
      drive(2, 9, i == 3, 0);
      check("lit_ld_lw1_hold", bus.state, LW1);
      tick();
    end
    drive(2, 9, 0, 0); check("lit_ld_mem2reg", bus.Mem2Reg, 1); tick();
    check("lit_ld_count", bus.instr_count, 2);

    // Fetch timeout: 16 FETCH cycles, then TRAP
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0);
      check("lit_to_fetch", bus.state, FETCH);
      tick();
    end
    check("lit_to_state", bus.state, TRAP);
    check("lit_to_cause", bus.trap_cause, 2);
    drive(0, 0, 0, 1); check("lit_to_trap", bus.trap, 1); tick();
    check("lit_to_release", bus.state, FETCH);
    drive(0, 0, 0, 1); tick();
    check("lit_ack_ignored", bus.state, FETCH);

    // Illegal opcode
    run(6, 0, 1, 1);
    drive(6, 0, 1, 0); check("lit_ill_retire", bus.retire, 0); tick();
    check("lit_ill_state", bus.state, TRAP);
    check("lit_ill_cause", bus.trap_cause, 1);
    check("lit_ill_count", bus.instr_count, 2);
    drive(6, 0, 0, 1); tick();

    // NOP
    run(3, 0, 1, 2);
    check("lit_nop_count", bus.instr_count, 3);

    // Branch, funct=1110
    run(1, 14, 1, 2);
    drive(1, 14, 0, 0);
    check("lit_br_state", bus.state, BRANCH);
    check("lit_br_type", bus.branchType, 2);
    tick();
    drive(1, 14, 0, 0);
    check("lit_br2_pcsrc", bus.PCSrc, 1);
    check("lit_br2_pcwrite", bus.PCWrite, 1);
    tick();
    check("lit_br_count", bus.instr_count, 4);

    run(1, 11, 1, 3);   // JALR
    run(4, 0, 1, 3);    // JAL
    run(1, 2, 1, 4);    // immediate ALU op
    check("lit_misc_count", bus.instr_count, 7);

    // Store with two waits
    run(2, 10, 1, 3);
    run(2, 10, 0, 2);
    drive(2, 10, 1, 0); check("lit_sw_retire", bus.retire, 1); tick();

    // Store completing exactly at the timeout count
    run(2, 10, 1, 3);
    run(2, 10, 0, 15);
    drive(2, 10, 1, 0);
    check("lit_swedge_state", bus.state, SW);
    check("lit_swedge_retire", bus.retire, 1);
    tick();
    check("lit_swedge_after", bus.state, FETCH);
    check("lit_swedge_count", bus.instr_count, 9);

    // Load timing out in LW1
    run(2, 9, 1, 3);
    run(2, 9, 0, 16);
    check("lit_lwto_state", bus.state, TRAP);
    check("lit_lwto_cause", bus.trap_cause, 2);
    drive(0, 0, 0, 1); tick();

    // Counter wrap at 2^CNT_W
    for (int i = 0; i < 7; i++) begin
      run(3, 0, 1, 2);
      if (i == 5) check("lit_wrap_15", bus.instr_count, 15);
    end
    check("lit_wrap_0", bus.instr_count, 0);
    run(3, 0, 1, 2);

    // Asynchronous reset during a SW wait
    run(2, 10, 1, 3);
    drive(2, 10, 0, 0);
    check("lit_ar_pre_memw", bus.MemW, 1);
    Reset = 1'b1;
    #1;
    check("lit_ar_state", bus.state, 0);
    check("lit_ar_memw", bus.MemW, 0);
    check("lit_ar_count", bus.instr_count, 0);
    check("lit_ar_cause", bus.trap_cause, 0);
    tick();
    Reset = 1'b0;
    run(0, 3, 1, 4);
    check("lit_post_rst_count", bus.instr_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
